sejf_code_ctrl: RTL
===================

Name: sejf_code_ctrl

Overview:
Parametrised safe-lock controller, the successor to the fixed sejf top.
- Quadrature-encoder digit entry with a user-programmable N-digit code.
- Wrong-attempt counter with timed lockout, plus a door tamper alarm.
- Sits between the debounced front-panel inputs (a, b, lock, open, doorCls) and the lock actuator.
- Exports digit, position and state for the LCD driver.

Parameters:
DIV, 1, tick prescaler; inputs are sampled once every DIV clocks (DIV>=1)
N_DIGITS, 4, code length in digits (1..8)
BASE, 10, digit radix (2..16); DW = clog2(BASE)
MAX_FAIL, 3, wrong codes that trigger lockout (>=1)
LOCKOUT_TICKS, 1000, lockout duration in ticks (>=1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
a  in  1  encoder channel A (debounced, synchronous)
b  in  1  encoder channel B
lock  in  1  lock button
open  in  1  digit-commit button
doorCls  in  1  1 = door closed
actuateLock  out  1  1 = bolt engaged
openCls  out  1  1 = unlocked indicator
alarm  out  1  sticky tamper flag
err  out  1  one-cycle rejected-command pulse
digit  out  DW  digit currently dialled
pos  out  clog2(N_DIGITS+1)  digits committed so far
state  out  2  00 UNLOCKED, 01 LOCKED, 10 LOCKOUT
failCnt  out  clog2(MAX_FAIL+1)  consecutive wrong codes

Behaviour:
Interface:
- One clock, clk.
- reset is synchronous and active-high.

Tick and sampling:
- Divider counts 0..DIV-1; tick is high for the one cycle at DIV-1 (DIV=1: every cycle).
- On tick, a, lock and open are compared with their previous tick-samples to detect rising edges; the samples are then updated.
- All state changes happen on the clk edge after a tick cycle.

Encoder:
- Rising edge of a with b=0: digit+1. Rising edge of a with b=1: digit-1.
- Digit wraps modulo BASE: BASE-1 -> 0 and 0 -> BASE-1.

Priority within one tick: lock > open > encoder. Only the highest-priority event is acted on; lower ones are dropped.

UNLOCKED (actuateLock=0, openCls=1):
- open: entry[pos] <= digit; pos <= pos+1; digit <= 0. If pos==N_DIGITS, nothing is stored and err pulses.
- lock with pos==N_DIGITS and doorCls=1: code <= entry; pos <= 0; digit <= 0; go to LOCKED.
- lock in any other case: err pulses and the entry is cleared (pos=0, digit=0).

LOCKED (actuateLock=1, openCls=0):
- open: commits the digit as in UNLOCKED.
- When the committing open fills the last digit, compare entry with code in that same update:
  - Match: go to UNLOCKED, failCnt=0, alarm=0.
  - Mismatch: failCnt+1 and err pulses. If the new failCnt==MAX_FAIL, go to LOCKOUT; otherwise stay LOCKED.
  - Either way pos=0 and digit=0.
- lock: clears the entry (pos=0, digit=0), no err.

LOCKOUT (actuateLock=1, openCls=0):
- All button and encoder events are ignored.
- The lockout counter counts ticks. After LOCKOUT_TICKS ticks: go to LOCKED, failCnt=0, pos=0, digit=0.

Alarm:
- Set on any clock with doorCls=0 while in LOCKED or LOCKOUT.
- Cleared only by reset or by entering UNLOCKED via a correct code.

Status outputs: actuateLock and openCls are registered and track state with no extra latency. The err pulse is exactly one clk cycle wide.

Reset (any time, including mid-entry or mid-lockout):
- state=UNLOCKED; code, entry, digit, pos, failCnt, lockout counter and divider = 0.
- actuateLock=0, openCls=1, alarm=0, err=0.
- Previous tick-samples = 0, so a button held through reset registers an edge on the first tick.

Test Plan:
1. Set DIV=1, N_DIGITS=2, BASE=10, MAX_FAIL=3, LOCKOUT_TICKS=8 for all scenarios.
   Reset, then give 3 a-pulses (b=0) -> digit=3. Pulse open -> pos=1. Give 1 a-pulse with b=1 -> digit=9. Pulse open -> pos=2.
   With doorCls=1, pulse lock -> state=01, actuateLock=1, openCls=0.
2. Code 3,9 stored. Enter 3,9 via open -> state=00, actuateLock=0, failCnt=0.
3. Code 3,9 stored. Enter 0,0 three times -> err pulses each time; failCnt goes 1 then 2, and the third attempt gives state=10. Pulses on a/open during the 8 lockout cycles are ignored. After 8 ticks -> state=01, failCnt=0.
4. In UNLOCKED with pos=2 and doorCls=0, pulse lock -> err pulse for 1 cycle, pos=0, state stays 00.
5. In LOCKED, drop doorCls to 0 -> alarm=1 and stays 1 after doorCls returns to 1. Enter the correct code -> alarm=0.
   Rerun with DIV=4: a single-cycle lock pulse landing between ticks is not detected.
6. Assert reset mid-lockout and mid-entry -> all outputs return to reset values on the next clk.
   Same tick with lock and open rising together in LOCKED at pos=1 -> entry cleared, no compare.

Source files
------------

// File: rtl/sejf_code_ctrl.sv
// Safe-lock controller: quadrature digit entry, programmable N-digit code,
// wrong-attempt lockout and door tamper alarm.
module sejf_code_ctrl #(
    parameter int DIV           = 1,
    parameter int N_DIGITS      = 4,
    parameter int BASE          = 10,
    parameter int MAX_FAIL      = 3,
    parameter int LOCKOUT_TICKS = 1000,
    localparam int DW = $clog2(BASE),
    localparam int PW = $clog2(N_DIGITS + 1),
    localparam int FW = $clog2(MAX_FAIL + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          a,
    input  logic          b,
    input  logic          lock,
    input  logic          open,
    input  logic          doorCls,
    output logic          actuateLock,
    output logic          openCls,
    output logic          alarm,
    output logic          err,
    output logic [DW-1:0] digit,
    output logic [PW-1:0] pos,
    output logic [1:0]    state,
    output logic [FW-1:0] failCnt
);
    localparam int DIVW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int LW   = (LOCKOUT_TICKS > 1) ? $clog2(LOCKOUT_TICKS) : 1;

    typedef enum logic [1:0] {
        S_UNLOCKED = 2'b00,
        S_LOCKED   = 2'b01,
        S_LOCKOUT  = 2'b10
    } state_t;

    state_t                      st;
    logic [DIVW-1:0]             div_cnt;
    logic [LW-1:0]               lo_cnt;
    logic                        tick;
    logic                        a_q, lock_q, open_q;
    logic                        a_rise, lock_rise, open_rise;
    logic [N_DIGITS-1:0][DW-1:0] entry, code, entry_next;
    logic [DW-1:0]               digit_step;
    logic                        last_digit, code_match, entry_full;

    assign state = st;

    assign tick      = (div_cnt == DIVW'(DIV - 1));
    assign a_rise    = tick & a & ~a_q;
    assign lock_rise = tick & lock & ~lock_q;
    assign open_rise = tick & open & ~open_q;

    // Encoder direction: b low counts up, b high counts down, both wrap at BASE.
    assign digit_step = b ? ((digit == '0) ? DW'(BASE - 1) : digit - DW'(1))
                          : ((digit == DW'(BASE - 1)) ? '0 : digit + DW'(1));

    assign entry_full = (pos == PW'(N_DIGITS));
    assign last_digit = (pos == PW'(N_DIGITS - 1));

    // NOTE: entry_next gets its default before the loop so no latch is inferred.
    always_comb begin
        entry_next = entry;
        for (int i = 0; i < N_DIGITS; i++) begin
            if (pos == PW'(i)) entry_next[i] = digit;
        end
    end

    assign code_match = (entry_next == code);

    // NOTE: sequential state uses non-blocking assignments so every register
    // sees the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (reset) begin
            div_cnt <= '0;
            a_q     <= 1'b0;
            lock_q  <= 1'b0;
            open_q  <= 1'b0;
        end else begin
            div_cnt <= tick ? '0 : div_cnt + DIVW'(1);
            if (tick) begin
                a_q    <= a;
                lock_q <= lock;
                open_q <= open;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st          <= S_UNLOCKED;
            actuateLock <= 1'b0;
            openCls     <= 1'b1;
            alarm       <= 1'b0;
            err         <= 1'b0;
            digit       <= '0;
            pos         <= '0;
            failCnt     <= '0;
            lo_cnt      <= '0;
            // NOTE: code and entry are only a few flops, so they are reset
            // along with the rest rather than left as unreset storage.
            entry       <= '0;
            code        <= '0;
        end else begin
            err <= 1'b0;
            if ((st != S_UNLOCKED) && !doorCls) alarm <= 1'b1;

            case (st)
                S_UNLOCKED: begin
                    if (lock_rise) begin
                        pos   <= '0;
                        digit <= '0;
                        if (entry_full && doorCls) begin
                            code        <= entry;
                            st          <= S_LOCKED;
                            actuateLock <= 1'b1;
                            openCls     <= 1'b0;
                        end else begin
                            err <= 1'b1;
                        end
                    end else if (open_rise) begin
                        if (entry_full) begin
                            err <= 1'b1;
                        end else begin
                            entry <= entry_next;
                            pos   <= pos + PW'(1);
                            digit <= '0;
                        end
                    end else if (a_rise) begin
                        digit <= digit_step;
                    end
                end

                S_LOCKED: begin
                    if (lock_rise) begin
                        pos   <= '0;
                        digit <= '0;
                    end else if (open_rise) begin
                        entry <= entry_next;
                        digit <= '0;
                        if (last_digit) begin
                            pos <= '0;
                            if (code_match) begin
                                st          <= S_UNLOCKED;
                                actuateLock <= 1'b0;
                                openCls     <= 1'b1;
                                failCnt     <= '0;
                                alarm       <= 1'b0;
                            end else begin
                                err     <= 1'b1;
                                failCnt <= failCnt + FW'(1);
                                if (failCnt == FW'(MAX_FAIL - 1)) begin
                                    st     <= S_LOCKOUT;
                                    lo_cnt <= '0;
                                end
                            end
                        end else begin
                            pos <= pos + PW'(1);
                        end
                    end else if (a_rise) begin
                        digit <= digit_step;
                    end
                end

                S_LOCKOUT: begin
                    if (tick) begin
                        if (lo_cnt == LW'(LOCKOUT_TICKS - 1)) begin
                            st      <= S_LOCKED;
                            lo_cnt  <= '0;
                            failCnt <= '0;
                            pos     <= '0;
                            digit   <= '0;
                        end else begin
                            lo_cnt <= lo_cnt + LW'(1);
                        end
                    end
                end

                default: begin
                    st          <= S_UNLOCKED;
                    actuateLock <= 1'b0;
                    openCls     <= 1'b1;
                end
            endcase
        end
    end
endmodule
